md_cart_responder: RTL

- Cartridge-side responder for the console cart bus.
- Decodes chip-select, output-enable, byte-write and TIME strobes from the board.
- Translates each access into a request on a generic word-wide memory port (SDRAM/BRAM controller) and returns read data on cart_data.
- Implements an SSF2-style 8-slot bank mapper and a TIME-mapped control register, so large ROMs and SRAM can be served by the FPGA.

---
 rtl/md_cart_pkg.sv | 25 ++
 rtl/md_cart_mapper.sv | 70 +++++++
 rtl/md_cart_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/md_cart_pkg.sv
// Shared types and constants for the cartridge responder.
// Build option: define CART_SRAM_EN to enable the battery-SRAM window.
package md_cart_pkg;

    // Bus transaction state of the responder
    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        HOLD
    } state_t;

    // TIME register offsets (A130F1 -> 0x78 ... A130FF -> 0x7F)
    localparam logic [6:0] TIME_CTRL    = 7'h78;
    localparam logic [6:0] TIME_BANK_LO = 7'h79;
    localparam logic [6:0] TIME_BANK_HI = 7'h7F;

    // Word-address bit that selects the upper 2 MB window
    localparam int         SRAM_SEL_BIT = 20;
    // SRAM sits on the low byte lane only
    localparam logic [1:0] SRAM_BE      = 2'b01;
    // Undriven upper byte of SRAM reads
    localparam logic [7:0] SRAM_PAD     = 8'hFF;

endpackage

// File: rtl/md_cart_mapper.sv
// Bank/control register file and cart-to-physical address translation.
// Build option: CART_SRAM_EN adds the sram_en / sram_wp control bits.
import md_cart_pkg::*;

module md_cart_mapper #(
    parameter int BANK_W = 6
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              time_wr,
    input  logic [6:0]        time_addr,
    input  logic [BANK_W-1:0] time_data,
    input  logic [20:0]       cart_address,
    output logic [23:0]       map_addr,
    output logic              map_sram,
    output logic              map_wp
);

    logic [BANK_W-1:0]  bank [8];
    logic [2:0]         slot;
    logic [BANK_W-1:0]  rom_bank;
    logic [BANK_W+17:0] rom_addr;
    logic [6:0]         bank_ofs;
    logic               bank_hit;

    assign slot     = cart_address[20:18];
    // Offset relative to the first bank register; addresses below wrap high
    assign bank_ofs = time_addr - TIME_BANK_LO;
    assign bank_hit = time_wr && (bank_ofs <= (TIME_BANK_HI - TIME_BANK_LO));

    // Bank registers: identity map out of reset, reloaded by TIME writes
    always_ff @(posedge MCLK) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                bank[i] <= BANK_W'(i);
            end
        end else if (bank_hit) begin
            bank[time_addr[2:0]] <= time_data;
        end
    end

    // Slot 0 holds the vector table and is pinned to bank 0
    assign rom_bank = (slot == 3'd0) ? '0 : bank[slot];
    assign rom_addr = {rom_bank, cart_address[17:0]};

`ifdef CART_SRAM_EN
    logic sram_en;
    logic sram_wp;

    // SRAM enable / write-protect control register
    always_ff @(posedge MCLK) begin
        if (reset) begin
            sram_en <= 1'b0;
            sram_wp <= 1'b0;
        end else if (time_wr && (time_addr == TIME_CTRL)) begin
            sram_en <= time_data[0];
            sram_wp <= time_data[1];
        end
    end

    assign map_sram = sram_en & cart_address[SRAM_SEL_BIT];
    assign map_wp   = sram_wp;
    assign map_addr = map_sram ? {9'b0, cart_address[14:0]} : 24'(rom_addr);
`else
    assign map_sram = 1'b0;
    assign map_wp   = 1'b0;
    assign map_addr = 24'(rom_addr);
`endif

endmodule

// File: rtl/md_cart_responder.sv
// Cart-bus responder: strobe edge detection and access FSM feeding a
// word-wide memory port, with the bank mapper as a sub-block.
// Build option: CART_SRAM_EN enables the SRAM window in the mapper.
import md_cart_pkg::*;

module md_cart_responder #(
    parameter int BANK_W  = 6,
    parameter int LAT_MAX = 24
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [20:0] cart_address,
    input  logic        cart_cs,
    input  logic        cart_oe,
    input  logic        cart_lwr,
    input  logic        cart_uwr,
    input  logic        cart_time,
    input  logic [15:0] cart_data_wr,
    output logic [15:0] cart_data,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    output logic        mem_sram,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rd_late
);

    localparam int CNT_W = $clog2(LAT_MAX + 1);

    logic             acc_rd, acc_wr, time_lw;
    logic             acc_rd_p1, acc_wr_p1, time_lw_p1;
    logic             rd_rise, wr_rise, time_rise;
    logic [23:0]      map_addr;
    logic             map_sram, map_wp;

    state_t           state, state_nx;
    logic [CNT_W-1:0] lat_cnt, lat_cnt_nx;
    logic [15:0]      cart_data_nx, mem_wdata_nx;
    logic [23:0]      mem_addr_nx;
    logic [1:0]       mem_be_nx;
    logic             mem_rd_nx, mem_wr_nx, mem_sram_nx, rd_late_nx;

    // Latency counter increment that sticks at LAT_MAX
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_W'(LAT_MAX)) begin
            return CNT_W'(LAT_MAX);
        end
        return v + CNT_W'(1);
    endfunction

    // SRAM is byte-wide; the upper lane reads as pulled-up
    function automatic logic [15:0] rd_fmt(input logic [15:0] d, input logic sram);
        return sram ? {SRAM_PAD, d[7:0]} : d;
    endfunction

    // TIME cycles never reach the memory port, even if CS is also asserted
    assign acc_rd  = cart_cs & cart_oe & ~cart_time;
    assign acc_wr  = cart_cs & (cart_lwr | cart_uwr) & ~cart_time;
    assign time_lw = cart_time & cart_lwr;

    assign rd_rise   = acc_rd  & ~acc_rd_p1;
    assign wr_rise   = acc_wr  & ~acc_wr_p1;
    assign time_rise = time_lw & ~time_lw_p1;

    md_cart_mapper #(
        .BANK_W(BANK_W)
    ) u_mapper (
        .MCLK        (MCLK),
        .reset       (reset),
        .time_wr     (time_rise),
        .time_addr   (cart_address[6:0]),
        .time_data   (cart_data_wr[BANK_W-1:0]),
        .cart_address(cart_address),
        .map_addr    (map_addr),
        .map_sram    (map_sram),
        .map_wp      (map_wp)
    );

    // Next-state and next-output decode for the access FSM
    always_comb begin
        state_nx     = state;
        lat_cnt_nx   = lat_cnt;
        cart_data_nx = cart_data;
        mem_addr_nx  = mem_addr;
        mem_rd_nx    = mem_rd;
        mem_wr_nx    = mem_wr;
        mem_be_nx    = mem_be;
        mem_wdata_nx = mem_wdata;
        mem_sram_nx  = mem_sram;
        rd_late_nx   = rd_late;
        case (state)
            IDLE: begin
                if (rd_rise) begin
                    mem_addr_nx = map_addr;
                    mem_sram_nx = map_sram;
                    mem_be_nx   = map_sram ? SRAM_BE : 2'b11;
                    mem_rd_nx   = 1'b1;
                    lat_cnt_nx  = '0;
                    state_nx    = RD_WAIT;
                end else if (wr_rise) begin
                    mem_addr_nx  = map_addr;
                    mem_sram_nx  = map_sram;
                    mem_be_nx    = map_sram ? SRAM_BE : {cart_uwr, cart_lwr};
                    mem_wdata_nx = cart_data_wr;
                    if (map_sram && map_wp) begin
                        state_nx = HOLD;
                    end else begin
                        mem_wr_nx = 1'b1;
                        state_nx  = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    cart_data_nx = rd_fmt(mem_rdata, mem_sram);
                    mem_rd_nx    = 1'b0;
                    if (lat_cnt >= CNT_W'(LAT_MAX)) begin
                        rd_late_nx = 1'b1;
                    end
                    state_nx = HOLD;
                end else begin
                    lat_cnt_nx = sat_inc(lat_cnt);
                end
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    mem_wr_nx = 1'b0;
                    state_nx  = HOLD;
                end
            end
            HOLD: begin
                if (!acc_rd && !acc_wr) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, strobe history and registered memory-port outputs
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            acc_rd_p1  <= 1'b0;
            acc_wr_p1  <= 1'b0;
            time_lw_p1 <= 1'b0;
            cart_data  <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            mem_sram   <= 1'b0;
            rd_late    <= 1'b0;
        end else begin
            state      <= state_nx;
            lat_cnt    <= lat_cnt_nx;
            acc_rd_p1  <= acc_rd;
            acc_wr_p1  <= acc_wr;
            time_lw_p1 <= time_lw;
            cart_data  <= cart_data_nx;
            mem_addr   <= mem_addr_nx;
            mem_rd     <= mem_rd_nx;
            mem_wr     <= mem_wr_nx;
            mem_be     <= mem_be_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_sram   <= mem_sram_nx;
            rd_late    <= rd_late_nx;
        end
    end

endmodule
